// File: rtl/tuner_ctrl_mc.sv
// tuner_ctrl_mc
// Multi-channel tuning drive controller. A time-multiplexed stream of phase
// samples, each tagged with a channel index, runs through one shared pipeline:
//   stage 1  register the sample and qualify the channel index
//   stage 2  wrap-aware phase error against the channel setpoint -> mag, sgn
//   stage 3  rate law (clamped proportional law between f_min and f_max)
//   update   per-channel OFF/SEEK/HOLD/FAULT state machine and output registers
// A sample strobed at edge t shows up on the outputs after edge t+3.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   enable[CH]        per-channel mode enable (level)
//   s_valid/s_ch/s_phase  sample strobe, channel tag, unsigned modular phase
//   fi_set[CH*W]      per-channel setpoints, channel c at [c*W +: W]
//   win, dz, gate     hold window, dead zone / re-seek threshold, full-rate threshold
//   k                 proportional gain (product shifted right by SHIFT)
//   f_min, f_max      rate bounds
//   to_lim            SEEK sample budget, 0 disables the timeout
//   drv_en, dir, rate, fault   per-channel drive outputs
//   upd_valid, upd_ch one-cycle pulse naming the channel just updated
//
// State table (per channel)
//   OFF   | channel disabled, no drive
//   SEEK  | driving toward setpoint, timeout counting samples
//   HOLD  | inside window, no drive, waits for error >= dz
//   FAULT | timeout expired, sticky until enable drops
module tuner_ctrl_mc #(
  parameter int CH    = 4,
  parameter int W     = 16,
  parameter int KW    = 16,
  parameter int SHIFT = 8,
  parameter int TW    = 16,
  localparam int CW   = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   enable,
  input  logic            s_valid,
  input  logic [CW-1:0]   s_ch,
  input  logic [W-1:0]    s_phase,
  input  logic [CH*W-1:0] fi_set,
  input  logic [W-1:0]    win,
  input  logic [W-1:0]    dz,
  input  logic [W-1:0]    gate,
  input  logic [KW-1:0]   k,
  input  logic [W-1:0]    f_min,
  input  logic [W-1:0]    f_max,
  input  logic [TW-1:0]   to_lim,
  output logic [CH-1:0]   drv_en,
  output logic [CH-1:0]   dir,
  output logic [CH*W-1:0] rate,
  output logic [CH-1:0]   fault,
  output logic            upd_valid,
  output logic [CW-1:0]   upd_ch
);

  localparam int PW = W + KW;
  localparam logic [CW:0] CH_LIM = (CW+1)'(CH);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_SEEK  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // ---------------- stage 1 ----------------
  logic          p1_vld_q;
  logic [CW-1:0] p1_ch_q;
  logic [W-1:0]  p1_phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_vld_q   <= 1'b0;
      p1_ch_q    <= '0;
      p1_phase_q <= '0;
    end else begin
      p1_vld_q   <= s_valid && ({1'b0, s_ch} < CH_LIM);
      p1_ch_q    <= s_ch;
      p1_phase_q <= s_phase;
    end
  end

  // ---------------- stage 2 ----------------
  logic [W-1:0] set_sel;
  logic [W-1:0] err;
  logic [W-1:0] mag_d;

  always_comb begin
    set_sel = '0;
    for (int c = 0; c < CH; c++) begin
      if (p1_ch_q == CW'(c)) set_sel = fi_set[c*W +: W];
    end
  end

  // Modular difference read as signed gives the shortest path across the wrap.
  // The most negative value has no positive twin, so it saturates.
  always_comb begin
    err = p1_phase_q - set_sel;
    if (err[W-1]) begin
      if (err == {1'b1, {(W-1){1'b0}}}) mag_d = {1'b0, {(W-1){1'b1}}};
      else                              mag_d = -err;
    end else begin
      mag_d = err;
    end
  end

  logic          p2_vld_q;
  logic [CW-1:0] p2_ch_q;
  logic [W-1:0]  p2_mag_q;
  logic          p2_sgn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p2_vld_q <= 1'b0;
      p2_ch_q  <= '0;
      p2_mag_q <= '0;
      p2_sgn_q <= 1'b0;
    end else begin
      p2_vld_q <= p1_vld_q;
      p2_ch_q  <= p1_ch_q;
      p2_mag_q <= mag_d;
      p2_sgn_q <= err[W-1];
    end
  end

  // ---------------- stage 3: rate law ----------------
  // Full-width product and sum so a large gain clamps to f_max instead of wrapping.
  logic [W-1:0]  diff;
  logic [PW-1:0] prod;
  logic [PW-1:0] scaled;
  logic [PW:0]   lin_sum;
  logic [W-1:0]  lin_rate;
  logic [W-1:0]  law_d;

  always_comb begin
    diff     = p2_mag_q - dz;
    prod     = PW'(k) * PW'(diff);
    scaled   = prod >> SHIFT;
    lin_sum  = (PW+1)'(f_min) + (PW+1)'(scaled);
    lin_rate = (lin_sum > (PW+1)'(f_max)) ? f_max : lin_sum[W-1:0];
    if (p2_mag_q >= gate)    law_d = f_max;
    else if (p2_mag_q >= dz) law_d = lin_rate;
    else                     law_d = f_min;
  end

  logic          p3_vld_q;
  logic [CW-1:0] p3_ch_q;
  logic [W-1:0]  p3_mag_q;
  logic          p3_sgn_q;
  logic [W-1:0]  p3_rate_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p3_vld_q  <= 1'b0;
      p3_ch_q   <= '0;
      p3_mag_q  <= '0;
      p3_sgn_q  <= 1'b0;
      p3_rate_q <= '0;
    end else begin
      p3_vld_q  <= p2_vld_q;
      p3_ch_q   <= p2_ch_q;
      p3_mag_q  <= p2_mag_q;
      p3_sgn_q  <= p2_sgn_q;
      p3_rate_q <= law_d;
    end
  end

  // ---------------- per-channel FSM ----------------
  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [TW-1:0] cnt_q   [CH];
  logic [TW-1:0] cnt_d   [CH];
  logic [W-1:0]  rate_q  [CH];
  logic [W-1:0]  rate_d  [CH];
  logic [CH-1:0] drv_en_q, drv_en_d;
  logic [CH-1:0] dir_q, dir_d;
  logic [CH-1:0] fault_q, fault_d;
  logic          upd_valid_q, upd_valid_d;
  logic [CW-1:0] upd_ch_q, upd_ch_d;

  always_comb begin
    logic          hit;
    state_t        cur;
    logic [TW-1:0] cur_cnt;
    logic [TW-1:0] cnt_inc;

    upd_valid_d = 1'b0;
    upd_ch_d    = upd_ch_q;
    drv_en_d    = drv_en_q;
    dir_d       = dir_q;
    fault_d     = fault_q;

    for (int c = 0; c < CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      rate_d[c]  = rate_q[c];
      hit        = p3_vld_q && (p3_ch_q == CW'(c));
      cur        = state_q[c];
      cur_cnt    = cnt_q[c];
      cnt_inc    = cnt_q[c] + 1'b1;

      if (!enable[c]) begin
        // Disable overrides everything, including a sample landing this edge.
        state_d[c]  = ST_OFF;
        cnt_d[c]    = '0;
        drv_en_d[c] = 1'b0;
        rate_d[c]   = '0;
        fault_d[c]  = 1'b0;
      end else begin
        if (cur == ST_OFF) begin
          // A sample arriving on the wake-up edge is treated as a first SEEK sample.
          cur         = ST_SEEK;
          cur_cnt     = '0;
          cnt_inc     = TW'(1);
          state_d[c]  = ST_SEEK;
          cnt_d[c]    = '0;
          drv_en_d[c] = 1'b1;
          rate_d[c]   = '0;
          fault_d[c]  = 1'b0;
        end

        if (hit) begin
          case (cur)
            ST_SEEK: begin
              upd_valid_d = 1'b1;
              upd_ch_d    = p3_ch_q;
              dir_d[c]    = p3_sgn_q;
              if (p3_mag_q <= win) begin
                state_d[c]  = ST_HOLD;
                cnt_d[c]    = cur_cnt;
                drv_en_d[c] = 1'b0;
                rate_d[c]   = '0;
              end else if ((to_lim != '0) && (cnt_inc >= to_lim)) begin
                // >= so a budget lowered mid-seek still trips.
                state_d[c]  = ST_FAULT;
                cnt_d[c]    = cnt_inc;
                drv_en_d[c] = 1'b0;
                rate_d[c]   = '0;
                fault_d[c]  = 1'b1;
              end else begin
                state_d[c]  = ST_SEEK;
                cnt_d[c]    = cnt_inc;
                drv_en_d[c] = 1'b1;
                rate_d[c]   = p3_rate_q;
              end
            end
            ST_HOLD: begin
              upd_valid_d = 1'b1;
              upd_ch_d    = p3_ch_q;
              if (p3_mag_q >= dz) begin
                state_d[c]  = ST_SEEK;
                cnt_d[c]    = '0;
                dir_d[c]    = p3_sgn_q;
                drv_en_d[c] = 1'b1;
                rate_d[c]   = p3_rate_q;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= ST_OFF;
        cnt_q[c]   <= '0;
        rate_q[c]  <= '0;
      end
      drv_en_q    <= '0;
      dir_q       <= '0;
      fault_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_ch_q    <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        rate_q[c]  <= rate_d[c];
      end
      drv_en_q    <= drv_en_d;
      dir_q       <= dir_d;
      fault_q     <= fault_d;
      upd_valid_q <= upd_valid_d;
      upd_ch_q    <= upd_ch_d;
    end
  end

  always_comb begin
    for (int c = 0; c < CH; c++) rate[c*W +: W] = rate_q[c];
  end

  assign drv_en    = drv_en_q;
  assign dir       = dir_q;
  assign fault     = fault_q;
  assign upd_valid = upd_valid_q;
  assign upd_ch    = upd_ch_q;

endmodule

// File: tb/tb_tuner_ctrl_mc.sv
// Directed bench for tuner_ctrl_mc: a vector table for the single-sample rate
// law and hysteresis behaviour, then hand-written sequences for timeout/fault,
// interleaved channels, enable drop in flight and reset in flight.
module tb_tuner_ctrl_mc;

  localparam int CH = 4;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   enable;
  logic            s_valid;
  logic [1:0]      s_ch;
  logic [W-1:0]    s_phase;
  logic [CH*W-1:0] fi_set;
  logic [W-1:0]    win, dz, gate, f_min, f_max;
  logic [15:0]     k;
  logic [15:0]     to_lim;
  logic [CH-1:0]   drv_en, dir, fault;
  logic [CH*W-1:0] rate;
  logic            upd_valid;
  logic [1:0]      upd_ch;

  tuner_ctrl_mc #(.CH(CH), .W(W), .KW(16), .SHIFT(8), .TW(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ch(s_ch),
    .s_phase(s_phase), .fi_set(fi_set), .win(win), .dz(dz), .gate(gate),
    .k(k), .f_min(f_min), .f_max(f_max), .to_lim(to_lim),
    .drv_en(drv_en), .dir(dir), .rate(rate), .fault(fault),
    .upd_valid(upd_valid), .upd_ch(upd_ch)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] rate_of(input int c);
    return rate[c*W +: W];
  endfunction

  // Send one sample and wait until its update is visible (after edge t+3).
  task automatic send_and_wait(input logic [1:0] ch, input logic [15:0] ph);
    s_ch = ch; s_phase = ph; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick(); tick(); tick();
  endtask

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] ph;
    logic [15:0] kk;
    logic        drv;
    logic        dr;
    logic [15:0] rt;
  } vec_t;

  vec_t vt [15];

  initial begin
    int upd_seen;
    logic [15:0] cc_ph [4];
    logic [15:0] cc_rt [4];
    logic        cc_dr [4];

    // ch, phase, k, drv_en, dir, rate   (setpoints: ch0=5000 ch1=1000 ch2=0x10 ch3=30000)
    vt[0]  = '{2'd1, 16'd1300,  16'd256,    1'b1, 1'b0, 16'd380};   // linear, mag 300
    vt[1]  = '{2'd2, 16'hFFF0,  16'd256,    1'b1, 1'b1, 16'd112};   // wrap, mag 32
    vt[2]  = '{2'd2, 16'd1200,  16'd256,    1'b1, 1'b0, 16'd4000};  // above gate
    vt[3]  = '{2'd3, 16'd29501, 16'hFFFF,   1'b1, 1'b1, 16'd4000};  // big gain clamps
    vt[4]  = '{2'd3, 16'd30010, 16'hFFFF,   1'b1, 1'b0, 16'd100};   // mag 10 < dz
    vt[5]  = '{2'd1, 16'd1002,  16'd256,    1'b0, 1'b0, 16'd0};     // mag 2 -> HOLD
    vt[6]  = '{2'd1, 16'd985,   16'd256,    1'b0, 1'b0, 16'd0};     // mag 15, stay, dir held
    vt[7]  = '{2'd1, 16'd1020,  16'd256,    1'b1, 1'b0, 16'd100};   // mag 20 -> SEEK
    vt[8]  = '{2'd1, 16'd998,   16'd256,    1'b0, 1'b1, 16'd0};     // mag 2 below -> HOLD, dir 1
    vt[9]  = '{2'd1, 16'd981,   16'd256,    1'b0, 1'b1, 16'd0};     // mag 19, stay
    vt[10] = '{2'd1, 16'd980,   16'd256,    1'b1, 1'b1, 16'd100};   // mag 20 -> SEEK
    vt[11] = '{2'd0, 16'd5500,  16'd256,    1'b1, 1'b0, 16'd4000};  // mag == gate
    vt[12] = '{2'd0, 16'd5499,  16'd256,    1'b1, 1'b0, 16'd579};   // mag gate-1
    vt[13] = '{2'd0, 16'd5003,  16'd256,    1'b1, 1'b0, 16'd100};   // mag 3 > win
    vt[14] = '{2'd0, 16'd37768, 16'd256,    1'b1, 1'b1, 16'd4000};  // err = -2^15 saturates

    cc_ph[0] = 16'd5300;  cc_rt[0] = 16'd380;  cc_dr[0] = 1'b0;
    cc_ph[1] = 16'd900;   cc_rt[1] = 16'd180;  cc_dr[1] = 1'b1;
    cc_ph[2] = 16'd536;   cc_rt[2] = 16'd4000; cc_dr[2] = 1'b0;
    cc_ph[3] = 16'd30050; cc_rt[3] = 16'd130;  cc_dr[3] = 1'b0;

    rst = 1'b1; enable = '0; s_valid = 1'b0; s_ch = '0; s_phase = '0;
    fi_set = {16'd30000, 16'h0010, 16'd1000, 16'd5000};
    win = 16'd2; dz = 16'd20; gate = 16'd500; k = 16'd256;
    f_min = 16'd100; f_max = 16'd4000; to_lim = 16'd0;
    tick(); tick();

    chk("rst.drv_en", drv_en, 0);
    chk("rst.dir", dir, 0);
    chk("rst.rate", rate, 0);
    chk("rst.fault", fault, 0);
    chk("rst.upd_valid", upd_valid, 0);
    chk("rst.upd_ch", upd_ch, 0);

    rst = 1'b0;
    tick();
    enable = 4'hF;
    tick();
    chk("wake.drv_en", drv_en, 4'hF);
    tick();

    for (int i = 0; i < 15; i++) begin
      k = vt[i].kk;
      send_and_wait(vt[i].ch, vt[i].ph);
      chk($sformatf("v%0d.upd_valid", i), upd_valid, 1);
      chk($sformatf("v%0d.upd_ch", i), upd_ch, vt[i].ch);
      chk($sformatf("v%0d.drv_en", i), drv_en[vt[i].ch], vt[i].drv);
      chk($sformatf("v%0d.dir", i), dir[vt[i].ch], vt[i].dr);
      chk($sformatf("v%0d.rate", i), rate_of(int'(vt[i].ch)), vt[i].rt);
      tick();
      chk($sformatf("v%0d.upd_pulse", i), upd_valid, 0);
    end
    k = 16'd256;

    // Timeout and fault on ch0.
    enable[0] = 1'b0;
    tick(); tick();
    chk("off0.drv_en", drv_en[0], 0);
    chk("off0.rate", rate_of(0), 0);
    to_lim = 16'd3;
    enable[0] = 1'b1;
    tick(); tick();
    chk("seek0.drv_en", drv_en[0], 1);
    send_and_wait(2'd0, 16'd5300);
    chk("to1.rate", rate_of(0), 380);
    chk("to1.fault", fault[0], 0);
    send_and_wait(2'd0, 16'd5300);
    chk("to2.fault", fault[0], 0);
    send_and_wait(2'd0, 16'd5300);
    chk("to3.fault", fault[0], 1);
    chk("to3.drv_en", drv_en[0], 0);
    chk("to3.rate", rate_of(0), 0);
    s_ch = 2'd0; s_phase = 16'd5300; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    upd_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (upd_valid) upd_seen++;
    end
    chk("fault.no_upd", upd_seen, 0);
    chk("fault.sticky", fault[0], 1);
    enable[0] = 1'b0;
    tick(); tick();
    chk("fault.clear", fault[0], 0);
    enable[0] = 1'b1;
    tick(); tick();
    chk("reseek.drv_en", drv_en[0], 1);
    send_and_wait(2'd0, 16'd5300);
    send_and_wait(2'd0, 16'd5300);
    chk("reseek2.fault", fault[0], 0);
    chk("reseek2.drv_en", drv_en[0], 1);
    send_and_wait(2'd0, 16'd5300);
    chk("reseek3.fault", fault[0], 1);
    to_lim = 16'd0;
    enable[0] = 1'b0;
    tick();
    enable[0] = 1'b1;
    tick(); tick();

    // Interleaved channels, one sample per clock.
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        s_ch = 2'(i); s_phase = cc_ph[i]; s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      tick();
      if (i >= 3 && i <= 6) begin
        chk($sformatf("cc%0d.upd_valid", i-3), upd_valid, 1);
        chk($sformatf("cc%0d.upd_ch", i-3), upd_ch, i-3);
        chk($sformatf("cc%0d.rate", i-3), rate_of(i-3), cc_rt[i-3]);
        chk($sformatf("cc%0d.dir", i-3), dir[i-3], cc_dr[i-3]);
      end else begin
        chk($sformatf("cc.idle%0d", i), upd_valid, 0);
      end
    end

    // Enable drop on the edge where the ch3 sample is applied.
    s_ch = 2'd3; s_phase = 16'd30300; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick(); tick();
    enable[3] = 1'b0;
    tick();
    chk("endrop.upd_valid", upd_valid, 0);
    chk("endrop.drv_en", drv_en[3], 0);
    chk("endrop.rate", rate_of(3), 0);
    tick();
    chk("endrop.upd_late", upd_valid, 0);

    // Reset with two samples in flight.
    enable[3] = 1'b1;
    tick(); tick();
    s_ch = 2'd0; s_phase = 16'd5300; s_valid = 1'b1;
    tick();
    s_ch = 2'd1; s_phase = 16'd1300;
    tick();
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst.drv_en", drv_en, 0);
    chk("midrst.rate", rate, 0);
    chk("midrst.dir", dir, 0);
    chk("midrst.upd_valid", upd_valid, 0);
    tick();
    rst = 1'b0;
    upd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (upd_valid) upd_seen++;
    end
    chk("midrst.flush", upd_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
